// File: rtl/dac_xy_ser_pkg.sv
// Shared constants and types for the dac_xy_ser serial DAC driver.
// Optional frame counter: define DAC_XY_SER_FCNT_EN.
package dac_xy_ser_pkg;

   localparam int NBIT    = 12;
   localparam int DIV_DEF = 4;

   // DAC control pins rest high (inactive)
   localparam logic CS_IDLE = 1'b1;
   localparam logic LD_IDLE = 1'b1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_CSUP  = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      LOAD  = S_LOAD,
      SHIFT = S_SHIFT,
      CSUP  = S_CSUP,
      LATCH = S_LATCH,
      DONE  = S_DONE
   } state_t;

   // States whose duration is measured in divider ticks
   function automatic logic timed_state(state_t s);
      return (s == SHIFT) || (s == CSUP) || (s == LATCH);
   endfunction

endpackage

// File: rtl/dac_xy_ser_if.sv
// Generator-side handshake and DAC pin bundle for dac_xy_ser.
// FCNT is present only with DAC_XY_SER_FCNT_EN defined.
interface dac_xy_ser_if;
   import dac_xy_ser_pkg::*;

   logic            en;
   logic [NBIT-1:0] X;
   logic [NBIT-1:0] Y;
   logic            st;
   logic            busy;
   logic            SCLK;
   logic            CS_X;
   logic            SDI_X;
   logic            LD_X;
   logic            SRI_Y;
   logic            LD_Y;
`ifdef DAC_XY_SER_FCNT_EN
   logic [15:0]     FCNT;

   modport master (output en, X, Y,
                   input  st, busy, SCLK, CS_X, SDI_X, LD_X, SRI_Y, LD_Y, FCNT);
   modport slave  (input  en, X, Y,
                   output st, busy, SCLK, CS_X, SDI_X, LD_X, SRI_Y, LD_Y, FCNT);
`else
   modport master (output en, X, Y,
                   input  st, busy, SCLK, CS_X, SDI_X, LD_X, SRI_Y, LD_Y);
   modport slave  (input  en, X, Y,
                   output st, busy, SCLK, CS_X, SDI_X, LD_X, SRI_Y, LD_Y);
`endif

endinterface

// File: rtl/dac_xy_tick.sv
// Phase divider: one-clock tick every DIV clocks, held at zero while clr is high.
module dac_xy_tick #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   logic [7:0] cnt;

   assign tick = !clr && (cnt == 8'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clr || tick) cnt <= '0;
      else                    cnt <= cnt + 8'd1;
   end

endmodule

// File: rtl/dac_xy_ser.sv
// Serial driver for the DAC8512 (X) / DAC8043 (Y) pair on a shared SCLK.
// Optional 16-bit frame counter output FCNT: define DAC_XY_SER_FCNT_EN.
module dac_xy_ser
   import dac_xy_ser_pkg::*;
#(
   parameter int DIV = DIV_DEF
) (
   input  logic         clk,
   input  logic         rst,
   dac_xy_ser_if.slave  bus
);

   state_t          state, nstate;
   logic [NBIT-1:0] sx, sy;
   logic [3:0]      bitcnt;
   logic            sclk;
   logic            tick;
   logic            div_clr;

   // Every timed-state exit happens on a tick, so the divider is at 0 on entry
   assign div_clr = !timed_state(state);

   dac_xy_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (div_clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (bus.en) nstate = LOAD;
         LOAD:    nstate = SHIFT;
         SHIFT:   if (tick && sclk && (bitcnt == 4'd0)) nstate = CSUP;
         CSUP:    if (tick) nstate = LATCH;
         LATCH:   if (tick) nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Falling SCLK advances data, except after bit 0 so lines hold through the latch
   always_ff @(posedge clk) begin
      if (rst) begin
         sx     <= '0;
         sy     <= '0;
         bitcnt <= '0;
         sclk   <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               sx     <= bus.X;
               sy     <= bus.Y;
               bitcnt <= 4'(NBIT - 1);
               sclk   <= 1'b0;
            end
            SHIFT: if (tick) begin
               sclk <= !sclk;
               if (sclk && (bitcnt != 4'd0)) begin
                  sx     <= sx << 1;
                  sy     <= sy << 1;
                  bitcnt <= bitcnt - 4'd1;
               end
            end
            default: sclk <= 1'b0;
         endcase
      end
   end

   assign bus.SCLK  = sclk;
   assign bus.SDI_X = sx[NBIT-1];
   assign bus.SRI_Y = sy[NBIT-1];
   assign bus.CS_X  = ((state == LOAD) || (state == SHIFT)) ? 1'b0 : CS_IDLE;
   assign bus.LD_X  = (state == LATCH) ? 1'b0 : LD_IDLE;
   assign bus.LD_Y  = (state == LATCH) ? 1'b0 : LD_IDLE;
   assign bus.st    = (state == DONE);
   assign bus.busy  = (state != IDLE);

`ifdef DAC_XY_SER_FCNT_EN
   logic [15:0] fcnt;

   always_ff @(posedge clk) begin
      if (rst)                fcnt <= '0;
      else if (state == DONE) fcnt <= fcnt + 16'd1;
   end

   assign bus.FCNT = fcnt;
`endif

endmodule

// File: doc/dac_xy_ser.md
Name: dac_xy_ser

Overview:
- Serial DAC driver directly downstream of the X/Y ramp generator.
- Captures the 12-bit X and Y codes and shifts them MSB-first to the DAC8512 (X channel) and DAC8043 (Y channel) over a shared SCLK.
- Latches both DACs simultaneously.
- Issues a one-clock st pulse back to the generator so it advances to the next point only after the current point is latched.

Parameters:
- DIV, 4: system clocks per SCLK half-period; legal range 1..255.
- NBIT, 12: DAC word width; fixed at 12 for both DACs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; frames start back-to-back while high.
- X  in  12  DAC8512 code from the generator.
- Y  in  12  DAC8043 code from the generator.
- st  out  1  one-clock step strobe to the generator, issued after the latch.
- busy  out  1  high from LOAD through DONE inclusive.
- SCLK  out  1  shared serial clock for both DACs.
- CS_X  out  1  DAC8512 chip select, active low.
- SDI_X  out  1  DAC8512 serial data.
- LD_X  out  1  DAC8512 load, active low.
- SRI_Y  out  1  DAC8043 serial data.
- LD_Y  out  1  DAC8043 load, active low.

Behaviour:
- Reset values, in effect from the edge on which rst is sampled high:
  - state = IDLE, SCLK = 0, CS_X = 1, LD_X = 1, LD_Y = 1.
  - SDI_X = 0, SRI_Y = 0, st = 0, busy = 0.
  - Shift registers and counters = 0.
- IDLE: if en = 1, go to LOAD; otherwise stay.
- LOAD (1 clk):
  - Register X into sx and Y into sy; CS_X goes 0.
  - Present bit 11 of each register on SDI_X / SRI_Y.
  - Go to SHIFT.
- SHIFT (NBIT * 2 * DIV clks):
  - Each bit period: SCLK = 0 for DIV clks, then SCLK = 1 for DIV clks.
  - Data is stable across the whole bit period; both DACs sample on the SCLK rising edge.
  - On each SCLK falling edge (end of a high phase), shift both registers left and present the next bit.
  - After bit 0's high phase: SCLK = 0, go to CSUP.
- CSUP (DIV clks): CS_X = 1, data lines held. Go to LATCH.
- LATCH (DIV clks): LD_X = LD_Y = 0. Both return to 1 on exit. Go to DONE.
- DONE (1 clk): st = 1, then go to IDLE.
  - The generator updates Q on this edge, so X/Y are new by the next LOAD.
- Frame length, DONE to next DONE with en held high: 1 (IDLE) + 1 (LOAD) + 24*DIV + DIV + DIV + 1 (DONE) = 26*DIV + 3 clks; 107 at DIV = 4.
- First frame after reset: st asserts 26*DIV + 2 clks after the first clk with en = 1.
- X/Y changing during a frame has no effect; only the LOAD-cycle values are sent.
- en dropping mid-frame: the current frame completes, including st; the block then stays in IDLE.
- rst mid-frame: abort on that edge, all outputs to reset values, no partial LD pulse, no st.
- Divider: an internal counter produces a phase tick every DIV clks, only in SHIFT, CSUP and LATCH. It restarts at 0 on state entry.
- Bit counter: 4 bits, counting 11 down to 0. No wrap; exit occurs at 0.

Optional Feature:
- Macro: DAC_XY_SER_FCNT_EN.
- When defined: adds output FCNT [15:0], a frame counter.
  - Resets to 0.
  - Increments on each DONE cycle, visible the clk after st.
  - Wraps 0xFFFF -> 0x0000.
  - Not affected by en.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (parameters include file):
  - NBIT = 12.
  - State encodings: IDLE, LOAD, SHIFT, CSUP, LATCH, DONE as 3-bit localparams.
  - DAC idle levels (CS/LD inactive = 1).
  - Default DIV.
- Sub-module dac_xy_tick: DIV counter with clear input and one-clock tick output. Instantiated once.
- FSM, shift registers and bit counter stay in dac_xy_ser.

Test Plan:
- Reset: assert rst 3 clks with en = 1 → all outputs at reset values; st never pulses during reset; first st 26*DIV + 2 = 106 clks after rst release (DIV = 4).
- Frame data: X = 0xABC, Y = 0x123, DIV = 4.
  - On SCLK rising edges, SDI_X samples 1010_1011_1100 and SRI_Y samples 0001_0010_0011.
  - Exactly 12 rising edges while CS_X = 0.
  - LD_X/LD_Y low exactly 4 clks; st high exactly 1 clk.
- Generator loop: connect a counter model that increments on st, starting at 0x7D0.
  - Five consecutive frames send 0x7D0 .. 0x7D4.
  - st period = 107 clks.
- en dropped at SHIFT bit 6 → frame completes with correct 12 bits and one st; no further CS_X fall while en = 0.
- rst pulsed at SHIFT bit 5 → next edge: CS_X = 1, SCLK = 0, LD_X/LD_Y never go low, no st; restart sends fresh X.
- DIV = 1 → SCLK high/low 1 clk each; DONE-to-DONE period = 29 clks; data correct. With DAC_XY_SER_FCNT_EN, FCNT = 3 after 3 frames.
